// File: rtl/multi_channel_command_unit_pkg.sv
// Shared opcodes, FSM encoding and helpers for the multi-channel command unit.
// CMD_ILLEGAL_DETECT_EN uses op_defined() to flag opcodes outside this set.
package cmd_pkg;

  localparam int CMD_W_DEF = 4;

  localparam int COMM_NOP     = 0;
  localparam int COMM_STAMP   = 1;
  localparam int COMM_HOLD    = 2;
  localparam int COMM_RELEASE = 3;
  localparam int COMM_FINISH  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  function automatic logic op_defined(
    input logic [31:0] op
  );
    return op <= 32'(COMM_FINISH);
  endfunction

endpackage

// File: rtl/multi_channel_command_unit_if.sv
// Pipe and command handshake bundle for the multi-channel command unit.
// master = upstream/downstream environment, slave = the unit itself.
interface multi_channel_command_unit_if #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 32,
  parameter int CMD_W  = 4,
  parameter int CHW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);

  logic [NUM_CH*DATA_W-1:0] pipe_tdata;
  logic [NUM_CH-1:0]        pipe_tvalid;
  logic [NUM_CH-1:0]        pipe_tready;
  logic [CMD_W-1:0]         cmd;
  logic [CHW-1:0]           cmd_ch;
  logic                     cmd_valid;
  logic                     cmd_ready;

  modport master (
    output pipe_tdata,
    output pipe_tvalid,
    output cmd_ready,
    input  pipe_tready,
    input  cmd,
    input  cmd_ch,
    input  cmd_valid
  );

  modport slave (
    input  pipe_tdata,
    input  pipe_tvalid,
    input  cmd_ready,
    output pipe_tready,
    output cmd,
    output cmd_ch,
    output cmd_valid
  );

endinterface

// File: rtl/multi_channel_command_unit_fifo.sv
// Single-clock synchronous FIFO; pointers carry an extra wrap bit
// so full and empty are distinguished without a separate counter.
module cmd_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/multi_channel_command_unit.sv
// Round-robin sink of NUM_CH command pipes feeding a buffered command port.
// CMD_ILLEGAL_DETECT_EN adds a sticky cmd_err for undefined opcodes.
module multi_channel_command_unit
  import cmd_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int DATA_W     = 32,
  parameter int CMD_W      = CMD_W_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              done,
  output logic [NUM_CH-1:0] fin_mask,
`ifdef CMD_ILLEGAL_DETECT_EN
  output logic              cmd_err,
`endif
  multi_channel_command_unit_if.slave bus
);

  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int EW  = CHW + CMD_W;

  state_e            state_q;
  logic [CHW-1:0]    rr_q;
  logic [CHW-1:0]    rr_nx;
  logic [NUM_CH-1:0] fin_q, fin_d;
  logic [NUM_CH-1:0] elig;
  logic [CHW-1:0]    grant;
  logic              found;
  int                idx;
  logic [CMD_W-1:0]  acc_op;
  logic              accept;
  logic              is_nop, is_fin;
  logic              illegal;
  logic              push, pop;
  logic              f_full, f_empty;
  logic [EW-1:0]     f_dout;
  logic              unused_tdata;

  assign elig = bus.pipe_tvalid & ~fin_q;

  // first eligible channel at or after the rr pointer, wrapping
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && elig[idx]) begin
        found = 1'b1;
        grant = CHW'(idx);
      end
    end
  end

  assign acc_op = bus.pipe_tdata[grant*DATA_W +: CMD_W];
  assign accept = (state_q == RUN) && !f_full && found;
  assign is_nop = (acc_op == CMD_W'(COMM_NOP));
  assign is_fin = (acc_op == CMD_W'(COMM_FINISH));
  assign rr_nx  = (grant == CHW'(NUM_CH - 1)) ? '0 : grant + CHW'(1);

`ifdef CMD_ILLEGAL_DETECT_EN
  assign illegal = !op_defined(32'(acc_op));
`else
  assign illegal = 1'b0;
`endif

  assign push = accept && !is_nop && !is_fin && !illegal;
  assign pop  = bus.cmd_valid && bus.cmd_ready;

  always_comb begin
    fin_d = fin_q;
    if (accept && is_fin) fin_d[grant] = 1'b1;
  end

  assign bus.pipe_tready = accept ?
    (NUM_CH'(1) << grant) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      fin_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            fin_q   <= '0;
          end
        end
        RUN: begin
          fin_q <= fin_d;
          if (accept) rr_q <= rr_nx;
          if (&fin_d) state_q <= DRAIN;
        end
        DRAIN: begin
          if (f_empty) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef CMD_ILLEGAL_DETECT_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state_q == IDLE && start) begin
      err_q <= 1'b0;
    end else if (accept && illegal) begin
      err_q <= 1'b1;
    end
  end

  assign cmd_err = err_q;
`endif

  cmd_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push),
    .din_i   ({grant, acc_op}),
    .pop_i   (pop),
    .dout_o  (f_dout),
    .full_o  (f_full),
    .empty_o (f_empty)
  );

  assign bus.cmd_valid = !f_empty;
  assign bus.cmd = f_empty ?
    '0 : f_dout[CMD_W-1:0];
  assign bus.cmd_ch = f_empty ?
    '0 : f_dout[EW-1:CMD_W];

  assign done     = (state_q == IDLE);
  assign fin_mask = fin_q;

  assign unused_tdata = ^bus.pipe_tdata;

endmodule

// File: tb/tb_multi_channel_command_unit.sv
// Scoreboard bench for multi_channel_command_unit (NUM_CH=2, FIFO_DEPTH=4).
// Optional cmd_err checks compile in with CMD_ILLEGAL_DETECT_EN.
module tb_multi_channel_command_unit;
  import cmd_pkg::*;

  localparam int NUM_CH = 2;
  localparam int DATA_W = 32;
  localparam int CMD_W  = 4;
  localparam int FDEP   = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              done;
  logic [NUM_CH-1:0] fin_mask;
`ifdef CMD_ILLEGAL_DETECT_EN
  logic              cmd_err;
`endif

  multi_channel_command_unit_if #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W),
    .CMD_W  (CMD_W)
  ) bus ();

  multi_channel_command_unit #(
    .NUM_CH     (NUM_CH),
    .DATA_W     (DATA_W),
    .CMD_W      (CMD_W),
    .FIFO_DEPTH (FDEP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .done     (done),
    .fin_mask (fin_mask),
`ifdef CMD_ILLEGAL_DETECT_EN
    .cmd_err  (cmd_err),
`endif
    .bus      (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [0:0] ch;
    logic [3:0] op;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, req);
    end
  endtask

  // monitor: samples just before the edge the pop happens on
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && bus.cmd_valid && bus.cmd_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected actual=%0h/%0h required=none",
                   bus.cmd_ch, bus.cmd);
        end else begin
          e = exp_q.pop_front();
          chk("sb_cmd", 32'(bus.cmd), 32'(e.op));
          chk("sb_ch", 32'(bus.cmd_ch), 32'(e.ch));
        end
      end
    end
  end

  task automatic set_ch(input int ch, input logic v,
                        input logic [3:0] op);
    bus.pipe_tvalid[ch] = v;
    bus.pipe_tdata[ch*DATA_W +: DATA_W] = DATA_W'(op);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    bus.pipe_tvalid = '0;
    bus.pipe_tdata = '0;
    bus.cmd_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // entered and left on a falling edge
  task automatic send(input int ch, input logic [3:0] op,
                      input bit pushes);
    bit got;
    exp_t e;
    got = 1'b0;
    set_ch(ch, 1'b1, op);
    for (int n = 0; n < 60; n++) begin
      #1;
      if (bus.pipe_tready[ch]) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (got) begin
      if (pushes) begin
        e.ch = 1'(ch);
        e.op = op;
        exp_q.push_back(e);
      end
      @(negedge clk);
    end else begin
      checks++;
      errors++;
      $display("FAIL send_timeout ch=%0d op=%0h", ch, op);
    end
    set_ch(ch, 1'b0, 4'h0);
  endtask

  task automatic wait_done(input string nm);
    for (int n = 0; n < 60; n++) begin
      #1;
      if (done) break;
      @(negedge clk);
    end
    chk(nm, 32'(done), 32'd1);
    chk({nm, "_sb"}, 32'(exp_q.size()), 32'd0);
  endtask

  logic [3:0] ops [6];
  int         acc;
  int         g;
  exp_t       ex;

  initial begin
    ops[0] = 4'd2; ops[1] = 4'd3; ops[2] = 4'd1;
    ops[3] = 4'd2; ops[4] = 4'd3; ops[5] = 4'd1;

    // reset state and basic run
    do_reset();
    #1;
    chk("rst_done", 32'(done), 32'd1);
    chk("rst_tready", 32'(bus.pipe_tready), 32'd0);
    chk("rst_valid", 32'(bus.cmd_valid), 32'd0);
    chk("rst_cmd", 32'(bus.cmd), 32'd0);
    chk("rst_ch", 32'(bus.cmd_ch), 32'd0);
    chk("rst_fin", 32'(fin_mask), 32'd0);
    @(negedge clk);
    bus.cmd_ready = 1'b1;
    do_start();
    #1;
    chk("run_done", 32'(done), 32'd0);
    @(negedge clk);
    send(0, 4'(COMM_STAMP), 1'b1);
    #1;
    chk("b_valid1", 32'(bus.cmd_valid), 32'd1);
    chk("b_cmd", 32'(bus.cmd), 32'd1);
    chk("b_ch", 32'(bus.cmd_ch), 32'd0);
    @(negedge clk);
    #1;
    chk("b_valid0", 32'(bus.cmd_valid), 32'd0);
    @(negedge clk);
    send(0, 4'(COMM_FINISH), 1'b0);
    #1;
    chk("b_fin01", 32'(fin_mask), 32'd1);
    @(negedge clk);
    send(1, 4'(COMM_FINISH), 1'b0);
    #1;
    chk("b_fin11", 32'(fin_mask), 32'd3);
    chk("b_drain", 32'(done), 32'd0);
    @(negedge clk);
    #1;
    chk("b_done2", 32'(done), 32'd1);

    // fairness
    do_reset();
    bus.cmd_ready = 1'b1;
    do_start();
    set_ch(0, 1'b1, 4'(COMM_STAMP));
    set_ch(1, 1'b1, 4'(COMM_STAMP));
    g = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("fair_grant", 32'(bus.pipe_tready),
          32'(1) << g);
      ex.ch = 1'(g);
      ex.op = 4'(COMM_STAMP);
      exp_q.push_back(ex);
      g = 1 - g;
      @(negedge clk);
    end
    set_ch(0, 1'b0, 4'h0);
    set_ch(1, 1'b0, 4'h0);
    send(0, 4'(COMM_FINISH), 1'b0);
    send(1, 4'(COMM_FINISH), 1'b0);
    wait_done("fair_done");

    // backpressure: 4 fit, then stall until ready
    do_reset();
    do_start();
    acc = 0;
    set_ch(0, 1'b1, ops[0]);
    for (int c = 0; c < 8; c++) begin
      #1;
      if (bus.pipe_tready[0]) begin
        ex.ch = 1'b0;
        ex.op = ops[acc];
        exp_q.push_back(ex);
        acc++;
      end
      @(negedge clk);
      set_ch(0, 1'b1, ops[acc]);
    end
    #1;
    chk("bp_accepted", 32'(acc), 32'd4);
    chk("bp_tready", 32'(bus.pipe_tready), 32'd0);
    chk("bp_valid", 32'(bus.cmd_valid), 32'd1);
    @(negedge clk);
    bus.cmd_ready = 1'b1;
    for (int c = 0; c < 30 && acc < 6; c++) begin
      #1;
      if (bus.pipe_tready[0]) begin
        ex.ch = 1'b0;
        ex.op = ops[acc];
        exp_q.push_back(ex);
        acc++;
      end
      @(negedge clk);
      if (acc < 6) set_ch(0, 1'b1, ops[acc]);
      else set_ch(0, 1'b0, 4'h0);
    end
    chk("bp_total", 32'(acc), 32'd6);
    send(0, 4'(COMM_FINISH), 1'b0);
    send(1, 4'(COMM_FINISH), 1'b0);
    wait_done("bp_done");

    // NOP discard and finished-channel filtering
    do_reset();
    bus.cmd_ready = 1'b1;
    do_start();
    send(1, 4'(COMM_NOP), 1'b0);
    #1;
    chk("nop_valid", 32'(bus.cmd_valid), 32'd0);
    @(negedge clk);
    send(1, 4'(COMM_FINISH), 1'b0);
    set_ch(1, 1'b1, 4'(COMM_STAMP));
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("fin_tready1", 32'(bus.pipe_tready), 32'd0);
      chk("fin_valid", 32'(bus.cmd_valid), 32'd0);
      @(negedge clk);
    end
    send(0, 4'(COMM_FINISH), 1'b0);
    set_ch(1, 1'b0, 4'h0);
    wait_done("nf_done");

    // drain holds until the buffered commands pop
    do_reset();
    do_start();
    send(0, 4'(COMM_STAMP), 1'b1);
    send(1, 4'(COMM_HOLD), 1'b1);
    send(0, 4'(COMM_RELEASE), 1'b1);
    send(0, 4'(COMM_FINISH), 1'b0);
    send(1, 4'(COMM_FINISH), 1'b0);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("dr_done0", 32'(done), 32'd0);
      chk("dr_valid", 32'(bus.cmd_valid), 32'd1);
      @(negedge clk);
    end
    bus.cmd_ready = 1'b1;
    wait_done("dr_done");

    // reset in the middle of drain
    do_reset();
    do_start();
    send(0, 4'(COMM_STAMP), 1'b1);
    send(1, 4'(COMM_HOLD), 1'b1);
    send(0, 4'(COMM_RELEASE), 1'b1);
    send(0, 4'(COMM_FINISH), 1'b0);
    send(1, 4'(COMM_FINISH), 1'b0);
    #1;
    chk("mr_drain", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    exp_q.delete();
    #1;
    chk("mr_valid", 32'(bus.cmd_valid), 32'd0);
    chk("mr_done", 32'(done), 32'd1);
    chk("mr_fin", 32'(fin_mask), 32'd0);
    @(negedge clk);
    rst = 1'b0;

`ifdef CMD_ILLEGAL_DETECT_EN
    do_reset();
    bus.cmd_ready = 1'b1;
    #1;
    chk("err_rst", 32'(cmd_err), 32'd0);
    @(negedge clk);
    do_start();
    send(0, 4'hA, 1'b0);
    #1;
    chk("err_valid", 32'(bus.cmd_valid), 32'd0);
    chk("err_set", 32'(cmd_err), 32'd1);
    @(negedge clk);
    send(0, 4'(COMM_FINISH), 1'b0);
    send(1, 4'(COMM_FINISH), 1'b0);
    wait_done("err_done");
    #1;
    chk("err_sticky", 32'(cmd_err), 32'd1);
    @(negedge clk);
    do_start();
    #1;
    chk("err_clear", 32'(cmd_err), 32'd0);
    @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
